// File: rtl/reg_file_read_port.sv
// Operand read-port responder for the per-SM vector register file: two single-ported
// banks selected by addr[0], shared with lane-masked writeback that wins any bank clash.
module reg_file_read_port #(
  parameter  int unsigned NUM_WARPS = 32,
  parameter  int unsigned NUM_REGS  = 32,
  parameter  int unsigned LANES     = 32,
  parameter  int unsigned DATA_W    = 32,
  localparam int unsigned WARP_W    = $clog2(NUM_WARPS),
  localparam int unsigned ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           read_start,
  input  logic [WARP_W-1:0]              warp_id,
  input  logic                           op1_req,
  input  logic [ADDR_W-1:0]              op1_addr,
  input  logic                           op2_req,
  input  logic [ADDR_W-1:0]              op2_addr,
  output logic                           op1_valid,
  output logic [LANES-1:0][DATA_W-1:0]   op1_data,
  output logic                           op2_valid,
  output logic [LANES-1:0][DATA_W-1:0]   op2_data,
  input  logic                           wb_valid,
  input  logic [WARP_W-1:0]              wb_warp_id,
  input  logic [ADDR_W-1:0]              wb_addr,
  input  logic [LANES-1:0]               wb_lane_mask,
  input  logic [LANES-1:0][DATA_W-1:0]   wb_data,
  output logic                           busy,
  output logic                           err
);

  localparam int unsigned IDX_W = WARP_W + ADDR_W - 1;
  localparam int unsigned DEPTH = NUM_WARPS * NUM_REGS / 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                               state;
  logic [WARP_W-1:0]                    warp_q;
  logic [ADDR_W-1:0]                    addr1_q, addr2_q;
  logic                                 pend1, pend2;
  logic                                 cap1, cap2;
  logic [LANES-1:0][DATA_W-1:0]         hold1, hold2;

  logic                                 bank1, bank2;
  logic [IDX_W-1:0]                     idx1, idx2, wb_idx;
  logic [1:0]                           wr_en, rd_en;
  logic [1:0][IDX_W-1:0]                rd_idx;
  logic                                 iss1, iss2;
  logic [1:0][LANES-1:0][DATA_W-1:0]    bank_q;

  always_comb begin
    bank1  = addr1_q[0];
    bank2  = addr2_q[0];
    idx1   = {warp_q, addr1_q[ADDR_W-1:1]};
    idx2   = {warp_q, addr2_q[ADDR_W-1:1]};
    wb_idx = {wb_warp_id, wb_addr[ADDR_W-1:1]};

    wr_en = '0;
    wr_en[wb_addr[0]] = wb_valid;

    // Port 2 waits behind port 1 on a shared bank unless both name the same register,
    // in which case the single read is delivered to both.
    iss1 = (state == S_ISSUE) && pend1 && !wr_en[bank1];
    iss2 = (state == S_ISSUE) && pend2 && !wr_en[bank2] &&
           (!pend1 || (bank1 != bank2) || (addr1_q == addr2_q));

    rd_en  = '0;
    rd_idx = '0;
    if (iss2) begin
      rd_en[bank2]  = 1'b1;
      rd_idx[bank2] = idx2;
    end
    if (iss1) begin
      rd_en[bank1]  = 1'b1;
      rd_idx[bank1] = idx1;
    end
  end

  // Each bank is split into one narrow array per lane so the lane mask maps onto
  // independent write enables.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] q;

      always_ff @(posedge clk) begin
        if (wr_en[b]) begin
          if (wb_lane_mask[l]) mem[wb_idx] <= wb_data[l];
        end else if (rd_en[b]) begin
          q <= mem[rd_idx[b]];
        end
      end

      assign bank_q[b][l] = q;
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      warp_q    <= '0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      pend1     <= 1'b0;
      pend2     <= 1'b0;
      cap1      <= 1'b0;
      cap2      <= 1'b0;
      hold1     <= '0;
      hold2     <= '0;
      op1_valid <= 1'b0;
      op2_valid <= 1'b0;
      op1_data  <= '0;
      op2_data  <= '0;
      err       <= 1'b0;
    end else begin
      err       <= read_start && (state != S_IDLE);
      op1_valid <= 1'b0;
      op2_valid <= 1'b0;
      cap1      <= iss1;
      cap2      <= iss2;
      if (cap1) hold1 <= bank_q[bank1];
      if (cap2) hold2 <= bank_q[bank2];

      case (state)
        S_IDLE: begin
          if (read_start) begin
            warp_q  <= warp_id;
            addr1_q <= op1_addr;
            addr2_q <= op2_addr;
            pend1   <= op1_req;
            pend2   <= op2_req;
            hold1   <= '0;
            hold2   <= '0;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (iss1) pend1 <= 1'b0;
          if (iss2) pend2 <= 1'b0;
          if (!(pend1 && !iss1) && !(pend2 && !iss2)) state <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_RESP;
        end
        S_RESP: begin
          op1_valid <= 1'b1;
          op2_valid <= 1'b1;
          op1_data  <= hold1;
          op2_data  <= hold2;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
